// File: rtl/cam_line_packetizer.sv
// cam_line_packetizer: splits camera lines into UDP-sized packets for an
// Ethernet TX FIFO. Each packet is a header word
// {MAGIC, line_no, line words, pkt_idx} followed by up to MAX_WORDS-1 data
// words. After each packet, etx_enable pulses once, and then the block stays
// idle for GAP_CYCLES cycles.
//
// Ports
//   clk, reset          single rising-edge clock, async active-high reset
//   linedone            pulse: a full line is in the camera FIFO
//   camer_tatal_data    words in that line, sampled with linedone
//   camer_fifo_empty    camera FIFO empty
//   cameradata          camera FIFO data, valid the cycle after camer_rden
//   camer_rden          camera FIFO read strobe
//   etx_full            TX FIFO full
//   etx_din / ewr_en    TX FIFO write data / strobe
//   tx_data_length      UDP payload bytes of the last packet
//   tx_total_length     IP total length of the last packet
//   etx_enable          pulse: packet complete in TX FIFO
//   line_drop           sticky: a line arrived with the pending slot full
module cam_line_packetizer #(
  parameter int unsigned MAX_WORDS  = 180,
  parameter int unsigned GAP_CYCLES = 64,
  parameter logic [15:0] MAGIC      = 16'hCA3E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        linedone,
  input  logic [15:0] camer_tatal_data,
  input  logic        camer_fifo_empty,
  input  logic [63:0] cameradata,
  output logic        camer_rden,
  input  logic        etx_full,
  output logic [63:0] etx_din,
  output logic        ewr_en,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        etx_enable,
  output logic        line_drop
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] PKT_DATA = CW'(MAX_WORDS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, HDR, STREAM, KICK, GAP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   words_q, words_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]   line_no_q, line_no_d;
  logic [15:0]   pkt_idx_q, pkt_idx_d;
  logic          pend_valid_q, pend_valid_d;
  logic [15:0]   pend_words_q, pend_words_d;
  logic          line_drop_q, line_drop_d;
  logic          inflight_q, inflight_d;
  logic          hold_valid_q, hold_valid_d;
  logic [63:0]   hold_data_q, hold_data_d;
  logic          wr_valid_q, wr_valid_d;
  logic [63:0]   wr_data_q, wr_data_d;
  logic          etx_enable_q, etx_enable_d;
  logic [15:0]   data_len_q, data_len_d;
  logic [15:0]   total_len_q, total_len_d;
  logic [15:0]   pkt_len;

  // Output slot drains whenever the TX FIFO can take a word.
  assign ewr_en = wr_valid_q & ~etx_full;

  // At most one read is in flight. With hold empty and the FIFO not full,
  // the output slot plus hold can always absorb it.
  assign camer_rden = (state_q == STREAM) & ~camer_fifo_empty & ~etx_full &
                      ~hold_valid_q & (pkt_cnt_q != PKT_DATA) &
                      (remaining_q != 16'd0);

  assign etx_din         = wr_data_q;
  assign etx_enable      = etx_enable_q;
  assign tx_data_length  = data_len_q;
  assign tx_total_length = total_len_q;
  assign line_drop       = line_drop_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      words_q      <= '0;
      remaining_q  <= '0;
      pkt_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      line_no_q    <= '0;
      pkt_idx_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_words_q <= '0;
      line_drop_q  <= 1'b0;
      inflight_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
      etx_enable_q <= 1'b0;
      data_len_q   <= '0;
      total_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      remaining_q  <= remaining_d;
      pkt_cnt_q    <= pkt_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      line_no_q    <= line_no_d;
      pkt_idx_q    <= pkt_idx_d;
      pend_valid_q <= pend_valid_d;
      pend_words_q <= pend_words_d;
      line_drop_q  <= line_drop_d;
      inflight_q   <= inflight_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      etx_enable_q <= etx_enable_d;
      data_len_q   <= data_len_d;
      total_len_q  <= total_len_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    remaining_d  = remaining_q;
    pkt_cnt_d    = pkt_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    line_no_d    = line_no_q;
    pkt_idx_d    = pkt_idx_q;
    pend_valid_d = pend_valid_q;
    pend_words_d = pend_words_q;
    line_drop_d  = line_drop_q;
    inflight_d   = camer_rden;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    wr_valid_d   = wr_valid_q & ~ewr_en;
    wr_data_d    = wr_data_q;
    etx_enable_d = 1'b0;
    data_len_d   = data_len_q;
    total_len_d  = total_len_q;
    pkt_len      = 16'((32'(pkt_cnt_q) + 32'd1) * 32'd8);

    // Ordering: output slot is older than hold, and hold is older than the
    // in-flight read.
    if (ewr_en && hold_valid_q) begin
      wr_valid_d   = 1'b1;
      wr_data_d    = hold_data_q;
      hold_valid_d = 1'b0;
    end
    if (inflight_q) begin
      if (!wr_valid_d) begin
        wr_valid_d = 1'b1;
        wr_data_d  = cameradata;
      end else begin
        hold_valid_d = 1'b1;
        hold_data_d  = cameradata;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          words_d      = pend_words_q;
          remaining_d  = pend_words_q;
          pend_valid_d = 1'b0;
          pkt_idx_d    = '0;
          state_d      = HDR;
        end else if (linedone) begin
          words_d     = camer_tatal_data;
          remaining_d = camer_tatal_data;
          pkt_idx_d   = '0;
          state_d     = HDR;
        end
      end
      HDR: begin
        pkt_cnt_d = '0;
        if (!etx_full) begin
          wr_valid_d = 1'b1;
          wr_data_d  = {MAGIC, line_no_q, words_q, pkt_idx_q};
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (camer_rden) begin
          remaining_d = remaining_q - 16'd1;
          pkt_cnt_d   = pkt_cnt_q + CW'(1);
        end
        // Close only after every word of this packet has reached the TX FIFO.
        if ((pkt_cnt_q == PKT_DATA || remaining_q == 16'd0) &&
            !inflight_q && !hold_valid_q && !wr_valid_q) begin
          etx_enable_d = 1'b1;
          data_len_d   = pkt_len;
          total_len_d  = pkt_len + 16'd28;
          state_d      = KICK;
        end
      end
      KICK: begin
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (remaining_q != 16'd0) begin
            pkt_idx_d = pkt_idx_q + 16'd1;
            state_d   = HDR;
          end else begin
            line_no_d = line_no_q + 16'd1;
            state_d   = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A line that is not started directly goes to the pending slot.
    // In IDLE, a pending line is consumed this cycle, so the slot is free.
    if (linedone && !(state_q == IDLE && !pend_valid_q)) begin
      if (!pend_valid_q || state_q == IDLE) begin
        pend_valid_d = 1'b1;
        pend_words_d = camer_tatal_data;
      end else begin
        line_drop_d = 1'b1;
      end
    end
  end

endmodule
